// File: rtl/key_filter_pulse.sv
// Key debouncer with single-cycle press pulse and debounced level output.
// Raw active-low key -> 2-flop synchronizer -> 4-state filter FSM.
// Optional auto-repeat of the press pulse while held: define KEY_REPEAT_EN.
module key_filter_pulse #(
  parameter int unsigned CNT_MAX    = 999999,
  parameter int unsigned REPEAT_DLY = 25000000,
  parameter int unsigned REPEAT_PER = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic po_flag,
  output logic key_state
);

  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_FLT = 2'd1,
    HELD      = 2'd2,
    REL_FLT   = 2'd3
  } state_e;

  // Repeat timing must leave at least one idle cycle between pulses.
  if (REPEAT_PER < 2 || REPEAT_DLY < 1) begin : g_bad_cfg
    $error("key_filter_pulse: REPEAT_PER must be >= 2 and REPEAT_DLY >= 1");
  end

  logic              sync1_q;
  logic              key_s;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              po_flag_q, po_flag_d;
  logic              key_state_q, key_state_d;
  logic              press_pulse_c;
  logic              rpt_pulse_c;

  // Two-flop synchronizer; idles high (released) out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      key_s   <= 1'b1;
    end else begin
      sync1_q <= key_in;
      key_s   <= sync1_q;
    end
  end

  // Filter state, debounce counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      po_flag_q   <= 1'b0;
      key_state_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      po_flag_q   <= po_flag_d;
      key_state_q <= key_state_d;
    end
  end

  // Next-state logic: a level must hold CNT_MAX+1 cycles to be accepted.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    press_pulse_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_FLT;
          cnt_d   = '0;
        end
      end
      PRESS_FLT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(CNT_MAX)) begin
          state_d       = HELD;
          press_pulse_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = REL_FLT;
          cnt_d   = '0;
        end
      end
      REL_FLT: begin
        if (!key_s) begin
          state_d = HELD;
        end else if (cnt_q == CNT_W'(CNT_MAX)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEY_REPEAT_EN
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_per_q, rpt_per_d;
  logic [RPT_W-1:0] rpt_lim_c;

  // Repeat counter and phase flag (first delay vs. steady period).
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q     <= '0;
      rpt_per_q <= 1'b0;
    end else begin
      rpt_q     <= rpt_d;
      rpt_per_q <= rpt_per_d;
    end
  end

  // Counts only in HELD, so it freezes across a release bounce.
  always_comb begin
    rpt_d       = rpt_q;
    rpt_per_d   = rpt_per_q;
    rpt_pulse_c = 1'b0;
    rpt_lim_c   = rpt_per_q ? RPT_W'(REPEAT_PER - 1) : RPT_W'(REPEAT_DLY - 1);
    if (press_pulse_c) begin
      rpt_d     = '0;
      rpt_per_d = 1'b0;
    end else if (state_q == HELD) begin
      if (rpt_q == rpt_lim_c) begin
        rpt_pulse_c = 1'b1;
        rpt_d       = '0;
        rpt_per_d   = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end
  end
`else
  // No auto-repeat: exactly one pulse per accepted press.
  always_comb begin
    rpt_pulse_c = 1'b0;
  end
`endif

  // Output next values, aligned with the state update.
  always_comb begin
    po_flag_d   = press_pulse_c | rpt_pulse_c;
    key_state_d = (state_d == HELD) || (state_d == REL_FLT);
  end

  assign po_flag   = po_flag_q;
  assign key_state = key_state_q;

endmodule

// File: tb/tb_key_filter_pulse.sv
// Scoreboard bench for key_filter_pulse: expected pulse cycles are queued
// per scenario and popped when po_flag is observed.
module tb_key_filter_pulse;

  localparam int unsigned CNT_MAX    = 4;
  localparam int unsigned REPEAT_DLY = 20;
  localparam int unsigned REPEAT_PER = 8;

  logic clk = 1'b0;
  logic rst;
  logic key_in;
  logic po_flag;
  logic key_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit prev_flag = 1'b0;
  int exp_q[$];

  always #5 clk = ~clk;

  key_filter_pulse #(
    .CNT_MAX   (CNT_MAX),
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .po_flag  (po_flag),
    .key_state(key_state)
  );

  // One clock: inputs applied at negedge, outputs observed at next negedge.
  task automatic step(input logic k, input logic r);
    int exp_cyc;
    key_in = k;
    rst    = r;
    @(posedge clk);
    @(negedge clk);
    if (po_flag === 1'b1) begin
      checks++;
      if (prev_flag) begin
        failures++;
        $display("FAIL po_flag_width cycle=%0d got high two cycles, want one", cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cycle=%0d got po_flag=1, want 0", cyc);
      end else begin
        exp_cyc = exp_q.pop_front();
        if (cyc !== exp_cyc) begin
          failures++;
          $display("FAIL pulse_cycle got cycle %0d, want cycle %0d", cyc, exp_cyc);
        end
      end
    end
    prev_flag = (po_flag === 1'b1);
    cyc++;
  endtask

  task automatic idle(input int n);
    cyc = -1000;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (po_flag !== 1'b0) begin
        failures++;
        $display("FAIL reset_po_flag got %b, want 0", po_flag);
      end
      checks++;
      if (key_state !== 1'b0) begin
        failures++;
        $display("FAIL reset_key_state got %b, want 0", key_state);
      end
    end
    idle(10);
  endtask

  task automatic test_clean_press();
    cyc = 0;
    exp_q.push_back(7);
`ifdef KEY_REPEAT_EN
    exp_q.push_back(27);
`endif
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0);
      if (i == 6 || i == 7 || i == 29) begin
        checks++;
        if (key_state !== (i >= 7)) begin
          failures++;
          $display("FAIL clean_key_state cycle=%0d got %b, want %b", i, key_state, (i >= 7));
        end
      end
    end
    for (int i = 30; i < 45; i++) begin
      step(1'b1, 1'b0);
      if (i == 36 || i == 37) begin
        checks++;
        if (key_state !== (i < 37)) begin
          failures++;
          $display("FAIL clean_release cycle=%0d got %b, want %b", i, key_state, (i < 37));
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL clean_missing_pulse got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
    idle(5);
  endtask

  task automatic test_press_bounce();
    cyc = 0;
    exp_q.push_back(12);
    for (int i = 0; i < 22; i++) begin
      step((i == 3 || i == 4) ? 1'b1 : 1'b0, 1'b0);
      if (i == 11 || i == 12) begin
        checks++;
        if (key_state !== (i >= 12)) begin
          failures++;
          $display("FAIL bounce_key_state cycle=%0d got %b, want %b", i, key_state, (i >= 12));
        end
      end
    end
    idle(12);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bounce_missing_pulse got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch();
    // 4-cycle and 5-cycle low runs are both too short to be accepted.
    for (int len = 4; len <= 5; len++) begin
      cyc = 0;
      for (int i = 0; i < 16; i++) begin
        step((i < len) ? 1'b0 : 1'b1, 1'b0);
        checks++;
        if (key_state !== 1'b0) begin
          failures++;
          $display("FAIL glitch%0d_key_state cycle=%0d got %b, want 0", len, i, key_state);
        end
      end
    end
  endtask

  task automatic test_min_press();
    // Shortest accepted low run: 6 cycles of key_in.
    cyc = 0;
    exp_q.push_back(7);
    for (int i = 0; i < 18; i++) begin
      step((i < 6) ? 1'b0 : 1'b1, 1'b0);
      if (i == 7 || i == 12 || i == 13) begin
        checks++;
        if (key_state !== (i < 13)) begin
          failures++;
          $display("FAIL min_key_state cycle=%0d got %b, want %b", i, key_state, (i < 13));
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL min_missing_pulse got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
    idle(5);
  endtask

  task automatic test_release_bounce();
    cyc = 0;
    exp_q.push_back(7);
    for (int i = 0; i < 40; i++) begin
      step((i >= 12 && i <= 14) || i >= 25 ? 1'b1 : 1'b0, 1'b0);
      if (i >= 7 && i <= 32) begin
        checks++;
        if (key_state !== (i < 32)) begin
          failures++;
          $display("FAIL relbounce_key_state cycle=%0d got %b, want %b", i, key_state, (i < 32));
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL relbounce_missing_pulse got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
    idle(5);
  endtask

  task automatic test_reset_mid_press();
    cyc = 0;
    exp_q.push_back(13);
    for (int i = 0; i < 26; i++) begin
      step(1'b0, (i == 4 || i == 5) ? 1'b1 : 1'b0);
      if (i == 4 || i == 5) begin
        checks++;
        if (po_flag !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_po_flag cycle=%0d got %b, want 0", i, po_flag);
        end
      end
      if (i == 7 || i == 12 || i == 13) begin
        checks++;
        if (key_state !== (i >= 13)) begin
          failures++;
          $display("FAIL rstmid_key_state cycle=%0d got %b, want %b", i, key_state, (i >= 13));
        end
      end
    end
    idle(12);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rstmid_missing_pulse got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_auto_repeat();
    cyc = 0;
    exp_q.push_back(7);
`ifdef KEY_REPEAT_EN
    exp_q.push_back(27);
    exp_q.push_back(35);
    exp_q.push_back(43);
    exp_q.push_back(51);
    exp_q.push_back(59);
`endif
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0);
    checks++;
    if (key_state !== 1'b1) begin
      failures++;
      $display("FAIL repeat_key_state got %b, want 1", key_state);
    end
    for (int i = 60; i < 75; i++) step(1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL repeat_missing_pulse got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (key_state !== 1'b0) begin
      failures++;
      $display("FAIL repeat_release got %b, want 0", key_state);
    end
  endtask

  initial begin
    key_in = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_glitch();
    test_min_press();
    test_release_bounce();
    test_reset_mid_press();
    test_auto_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_filter_pulse.md
KEY_FILTER_PULSE -- requirements
Module: key_filter_pulse

Interface
REQ-001 SHALL have parameter CNT_MAX, default 999999, meaning the debounce count (cycles minus one) a level must hold stable; 20 ms at 50 MHz.
REQ-002 SHALL have parameter REPEAT_DLY, default 25000000, meaning the cycles from the press pulse to the first auto-repeat pulse (used only with KEY_REPEAT_EN).
REQ-003 SHALL have parameter REPEAT_PER, default 5000000, meaning the cycles between successive auto-repeat pulses; legal values are 2 or more (used only with KEY_REPEAT_EN).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port key_in, input, 1 bit: raw mechanical key, asynchronous, active-low (0 = pressed).
REQ-007 SHALL have port po_flag, output, 1 bit: registered single-cycle pulse per accepted press; this is the pi_flag source for the downstream pulse divider.
REQ-008 SHALL have port key_state, output, 1 bit: registered debounced key level (1 = pressed).

Function
REQ-009 SHALL pass key_in through a 2-flop synchronizer; the second flop is key_s, and only key_s feeds the logic.
REQ-010 SHALL implement FSM states IDLE, PRESS_FLT, HELD and REL_FLT, plus one debounce counter wide enough to hold CNT_MAX.
REQ-011 SHALL, in IDLE with key_s=0, go to PRESS_FLT with cnt<=0; with key_s=1 it stays in IDLE.
REQ-012 SHALL, in PRESS_FLT: key_s=1 -> IDLE with cnt<=0 (bounce, no pulse); else cnt==CNT_MAX -> HELD with po_flag<=1; else cnt<=cnt+1.
REQ-013 SHALL, in HELD with key_s=1, go to REL_FLT with cnt<=0.
REQ-014 SHALL, in REL_FLT: key_s=0 -> HELD with no pulse; else cnt==CNT_MAX -> IDLE; else cnt<=cnt+1.
REQ-015 SHALL assert po_flag exactly CNT_MAX+3 cycles after the first rising edge that samples key_in low, provided key_in stays low throughout.
REQ-016 SHALL hold po_flag high for exactly one cycle; it SHALL never be high in two consecutive cycles.
REQ-017 SHALL drive key_state=1 exactly while the state is HELD or REL_FLT, updated on the same edge as the state.
REQ-018 SHALL never produce a pulse from a low run shorter than CNT_MAX+1 cycles of key_s.
REQ-019 SHALL never increment the counter past CNT_MAX; there is no wrap-around.

Reset
REQ-020 SHALL set, while rst=1 at a clock edge: both synchronizer flops=1, state=IDLE, cnt=0, repeat counter=0, po_flag=0, key_state=0.
REQ-021 SHALL, on reset mid-operation, abandon the filter in progress; if key_in is still low after reset, a full new filter runs and yields one pulse CNT_MAX+3 cycles after the first post-reset edge.

Configuration
REQ-022 SHALL, when macro KEY_REPEAT_EN is defined, add a repeat counter that clears on the PRESS_FLT->HELD transition, counts in HELD, freezes in REL_FLT and resumes on REL_FLT->HELD.
REQ-023 SHALL, with KEY_REPEAT_EN defined, pulse po_flag REPEAT_DLY cycles after the press pulse, then every REPEAT_PER cycles while in HELD.
REQ-024 SHALL, when KEY_REPEAT_EN is undefined, omit the repeat logic entirely and produce exactly one po_flag per accepted press.

Verification
Bench parameters: CNT_MAX=4, REPEAT_DLY=20, REPEAT_PER=8. Cycle 0 is the first edge that samples key_in low.
REQ-025 SHALL cover a clean press: key_in low at cycle 0 and held 30 cycles -> a single po_flag at cycle 7, and key_state=1 from cycle 7; release -> key_state=0 7 cycles after release.
REQ-026 SHALL cover press bounce: key_in low 3, high 2, then low steady -> no pulse during bounce, and exactly one po_flag 7 cycles after the steady low begins.
REQ-027 SHALL cover a glitch: key_in low for 4 cycles, then high -> po_flag and key_state remain 0.
REQ-028 SHALL cover release bounce: while in HELD, key_in high 3 cycles then low -> no extra pulse, and key_state stays 1 throughout.
REQ-029 SHALL cover reset mid-press: rst=1 at cycle 4 for 2 cycles with key_in held low -> po_flag=0 during reset, then one pulse 7 cycles after rst falls.
REQ-030 SHALL cover auto-repeat: key_in held low 60 cycles with KEY_REPEAT_EN defined -> po_flag at cycles 7, 27, 35, 43, 51, 59; without the macro -> only cycle 7.
